// File: rtl/inv_bfly_pkg.sv
// -----------------------------------------------------------------------------
// inv_bfly_pkg
// Shared definitions for the radix-2 inverse butterfly pipeline.
//   INV_BFLY_STAGES : number of register stages between input and output
//   SAT_W           : working width handed to the saturation helper
//   sat_res_t       : saturation result (clipped value + clip flag)
//   sat_nbd()       : clip a signed value into an i_nbd-bit two's-complement
//                     range and report whether clipping happened
// -----------------------------------------------------------------------------
package inv_bfly_pkg;

  localparam int INV_BFLY_STAGES = 3;
  localparam int SAT_W           = 32;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  // Callers sign-extend into SAT_W bits first; the clipped result always fits
  // in the low i_nbd bits of val.
  function automatic sat_res_t sat_nbd(input logic signed [SAT_W-1:0] i_v,
                                       input int                      i_nbd);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    hi      = (32'sd1 <<< (i_nbd - 1)) - 32'sd1;
    lo      = -hi - 32'sd1;
    res.sat = 1'b0;
    res.val = i_v;
    if (i_v > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (i_v < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/cplx_conj_mult.sv
// -----------------------------------------------------------------------------
// cplx_conj_mult
// Stages S2 and S3 of the inverse butterfly: conj(w) * d with a truncating
// (floor) rescale, plus the sum path delayed to stay aligned with it.
// Flow control lives in the parent; this block only loads when told to.
//   i_clock, i_reset            : clock, synchronous active-high reset
//   i_s2_load                   : capture S1 data into the partial products
//   i_s3_load                   : capture S2 data into the output registers
//   i_diff_real/imag  [NBD+1]   : d = X - Y from S1
//   i_w_real/imag     [NBT]     : twiddle w (not conjugated) from S1
//   i_sum_real/imag   [NBD+1]   : X + Y from S1
//   o_x_real/imag     [NBD]     : saturated sum
//   o_y_real/imag     [NBD]     : saturated conj(w) * d >>> (NBT-1)
//   o_sat                       : any of the four outputs clipped
// -----------------------------------------------------------------------------
module cplx_conj_mult
  import inv_bfly_pkg::*;
#(
  parameter int NBD = 8,
  parameter int NBT = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_s2_load,
  input  logic                  i_s3_load,
  input  logic signed [NBD:0]   i_diff_real,
  input  logic signed [NBD:0]   i_diff_imag,
  input  logic signed [NBT-1:0] i_w_real,
  input  logic signed [NBT-1:0] i_w_imag,
  input  logic signed [NBD:0]   i_sum_real,
  input  logic signed [NBD:0]   i_sum_imag,
  output logic signed [NBD-1:0] o_x_real,
  output logic signed [NBD-1:0] o_x_imag,
  output logic signed [NBD-1:0] o_y_real,
  output logic signed [NBD-1:0] o_y_imag,
  output logic                  o_sat
);

  localparam int DW = NBD + 1;     // sum/diff width
  localparam int PW = NBD + NBT + 1; // partial product width
  localparam int AW = PW + 1;      // one guard bit for the product add/sub

  // S2 registers
  logic signed [PW-1:0] r_rr;
  logic signed [PW-1:0] r_ii;
  logic signed [PW-1:0] r_ir;
  logic signed [PW-1:0] r_ri;
  logic signed [DW-1:0] r_sum2_real;
  logic signed [DW-1:0] r_sum2_imag;

  // S3 registers (drive the outputs directly)
  logic signed [NBD-1:0] r_x_real;
  logic signed [NBD-1:0] r_x_imag;
  logic signed [NBD-1:0] r_y_real;
  logic signed [NBD-1:0] r_y_imag;
  logic                  r_sat;

  logic signed [AW-1:0] w_yr_acc;
  logic signed [AW-1:0] w_yi_acc;
  logic signed [AW-1:0] w_yr_sh;
  logic signed [AW-1:0] w_yi_sh;
  sat_res_t             w_sat_xr;
  sat_res_t             w_sat_xi;
  sat_res_t             w_sat_yr;
  sat_res_t             w_sat_yi;
  logic                 w_unused_sat_hi;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rr        <= '0;
      r_ii        <= '0;
      r_ir        <= '0;
      r_ri        <= '0;
      r_sum2_real <= '0;
      r_sum2_imag <= '0;
    end else if (i_s2_load) begin
      r_rr        <= PW'(i_diff_real) * PW'(i_w_real);
      r_ii        <= PW'(i_diff_imag) * PW'(i_w_imag);
      r_ir        <= PW'(i_diff_imag) * PW'(i_w_real);
      r_ri        <= PW'(i_diff_real) * PW'(i_w_imag);
      r_sum2_real <= i_sum_real;
      r_sum2_imag <= i_sum_imag;
    end
  end

  // conj(w) * d = (dr*wr + di*wi) + j(di*wr - dr*wi); the shift floors, no
  // rounding constant, so results can sit one LSB below the exact quotient.
  assign w_yr_acc = AW'(r_rr) + AW'(r_ii);
  assign w_yi_acc = AW'(r_ir) - AW'(r_ri);
  assign w_yr_sh  = w_yr_acc >>> (NBT - 1);
  assign w_yi_sh  = w_yi_acc >>> (NBT - 1);

  assign w_sat_xr = sat_nbd(SAT_W'(r_sum2_real), NBD);
  assign w_sat_xi = sat_nbd(SAT_W'(r_sum2_imag), NBD);
  assign w_sat_yr = sat_nbd(SAT_W'(w_yr_sh), NBD);
  assign w_sat_yi = sat_nbd(SAT_W'(w_yi_sh), NBD);

  // After clipping only the low NBD bits carry information.
  assign w_unused_sat_hi = ^{w_sat_xr.val[SAT_W-1:NBD], w_sat_xi.val[SAT_W-1:NBD],
                             w_sat_yr.val[SAT_W-1:NBD], w_sat_yi.val[SAT_W-1:NBD]};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_x_real <= '0;
      r_x_imag <= '0;
      r_y_real <= '0;
      r_y_imag <= '0;
      r_sat    <= 1'b0;
    end else if (i_s3_load) begin
      r_x_real <= w_sat_xr.val[NBD-1:0];
      r_x_imag <= w_sat_xi.val[NBD-1:0];
      r_y_real <= w_sat_yr.val[NBD-1:0];
      r_y_imag <= w_sat_yi.val[NBD-1:0];
      r_sat    <= w_sat_xr.sat | w_sat_xi.sat | w_sat_yr.sat | w_sat_yi.sat;
    end
  end

  assign o_x_real = r_x_real;
  assign o_x_imag = r_x_imag;
  assign o_y_real = r_y_real;
  assign o_y_imag = r_y_imag;
  assign o_sat    = r_sat;

endmodule

// File: rtl/inv_butterfly_pipe.sv
// -----------------------------------------------------------------------------
// inv_butterfly_pipe
// Three-stage radix-2 inverse butterfly: x = X + Y, y = conj(w) * (X - Y),
// undoing the forward unit's halving butterfly.
//
// Handshake: a word moves on a rising edge when valid && ready are both high
// on that interface (i_valid/o_ready upstream, o_valid/i_ready downstream).
// o_ready depends combinationally on i_ready only; o_valid is registered and
// the output registers hold while o_valid && !i_ready.
//
// Ports:
//   i_clock, i_reset                  : clock, synchronous active-high reset
//   i_valid / o_ready                 : input handshake
//   i_x_real/imag, i_y_real/imag [NBD]: input pair X, Y
//   i_twiddle_real/imag          [NBT]: twiddle w, Q1.(NBT-1), not conjugated
//   o_valid / i_ready                 : output handshake
//   o_x_real/imag, o_y_real/imag [NBD]: recovered x, y
//   o_sat                             : any output component clipped
// -----------------------------------------------------------------------------
module inv_butterfly_pipe
  import inv_bfly_pkg::*;
#(
  parameter int NBD = 8,
  parameter int NBT = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic signed [NBD-1:0] i_x_real,
  input  logic signed [NBD-1:0] i_x_imag,
  input  logic signed [NBD-1:0] i_y_real,
  input  logic signed [NBD-1:0] i_y_imag,
  input  logic signed [NBT-1:0] i_twiddle_real,
  input  logic signed [NBT-1:0] i_twiddle_imag,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic signed [NBD-1:0] o_x_real,
  output logic signed [NBD-1:0] o_x_imag,
  output logic signed [NBD-1:0] o_y_real,
  output logic signed [NBD-1:0] o_y_imag,
  output logic                  o_sat
);

  localparam int STG = INV_BFLY_STAGES;
  localparam int DW  = NBD + 1;

  // Stage valid flags: bit 0 = S1, bit STG-1 = S3 (the output stage).
  logic [STG-1:0] r_vld;
  logic [STG-1:0] w_en;
  logic [STG-1:0] w_vld_in;
  logic           w_blk;

  logic signed [DW-1:0]  r_sum_real;
  logic signed [DW-1:0]  r_sum_imag;
  logic signed [DW-1:0]  r_diff_real;
  logic signed [DW-1:0]  r_diff_imag;
  logic signed [NBT-1:0] r_w_real;
  logic signed [NBT-1:0] r_w_imag;
  logic                  w_s1_load;

  // A stage may load when it is empty or its content moves on this cycle.
  // Walking from the output back, a stage is blocked only if it and every
  // stage after it is full and the downstream consumer is not ready, which
  // collapses bubbles and gives the single i_ready -> o_ready path.
  always_comb begin
    w_en  = '0;
    w_blk = !i_ready;
    for (int k = STG - 1; k >= 0; k--) begin
      w_blk   = w_blk && r_vld[k];
      w_en[k] = !w_blk;
    end
  end

  assign w_vld_in  = {r_vld[STG-2:0], i_valid};
  assign w_s1_load = w_en[0] && i_valid;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vld       <= '0;
      r_sum_real  <= '0;
      r_sum_imag  <= '0;
      r_diff_real <= '0;
      r_diff_imag <= '0;
      r_w_real    <= '0;
      r_w_imag    <= '0;
    end else begin
      r_vld <= (w_en & w_vld_in) | (~w_en & r_vld);
      if (w_s1_load) begin
        r_sum_real  <= DW'(i_x_real) + DW'(i_y_real);
        r_sum_imag  <= DW'(i_x_imag) + DW'(i_y_imag);
        r_diff_real <= DW'(i_x_real) - DW'(i_y_real);
        r_diff_imag <= DW'(i_x_imag) - DW'(i_y_imag);
        r_w_real    <= i_twiddle_real;
        r_w_imag    <= i_twiddle_imag;
      end
    end
  end

  cplx_conj_mult #(
    .NBD(NBD),
    .NBT(NBT)
  ) u_cmul (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_s2_load  (w_en[1] && r_vld[0]),
    .i_s3_load  (w_en[2] && r_vld[1]),
    .i_diff_real(r_diff_real),
    .i_diff_imag(r_diff_imag),
    .i_w_real   (r_w_real),
    .i_w_imag   (r_w_imag),
    .i_sum_real (r_sum_real),
    .i_sum_imag (r_sum_imag),
    .o_x_real   (o_x_real),
    .o_x_imag   (o_x_imag),
    .o_y_real   (o_y_real),
    .o_y_imag   (o_y_imag),
    .o_sat      (o_sat)
  );

  assign o_ready = w_en[0];
  assign o_valid = r_vld[STG-1];

endmodule

// File: tb/tb_inv_butterfly_pipe.sv
module tb_inv_butterfly_pipe;

  localparam int NBD = 8;
  localparam int NBT = 8;
  localparam int W   = 33;  // {x_re, x_im, y_re, y_im, sat}
  localparam int CW  = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  i_reset = 1'b1;
  logic                  i_valid = 1'b0;
  logic                  o_ready;
  logic signed [NBD-1:0] i_x_real = '0, i_x_imag = '0, i_y_real = '0, i_y_imag = '0;
  logic signed [NBT-1:0] i_twiddle_real = '0, i_twiddle_imag = '0;
  logic                  o_valid;
  logic                  i_ready = 1'b1;
  logic signed [NBD-1:0] o_x_real, o_x_imag, o_y_real, o_y_imag;
  logic                  o_sat;

  inv_butterfly_pipe #(.NBD(NBD), .NBT(NBT)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_x_real(i_x_real), .i_x_imag(i_x_imag), .i_y_real(i_y_real), .i_y_imag(i_y_imag),
    .i_twiddle_real(i_twiddle_real), .i_twiddle_imag(i_twiddle_imag),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_x_real(o_x_real), .o_x_imag(o_x_imag), .o_y_real(o_y_real), .o_y_imag(o_y_imag),
    .o_sat(o_sat)
  );

  // ---------------- counters / scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  int n_in    = 0;
  int n_out   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rt_q[$];       // {round_trip_flag, orig x_re, x_im, y_re, y_im}
  logic [W-1:0] drv_orig = '0;

  function automatic void check(string nm, int act, int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void check_w(string nm, logic [CW-1:0] act, logic [CW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void check_tol(string nm, int diff, int bound);
    n_total++;
    if (diff > bound || diff < -bound) begin
      n_bad++;
      $display("FAIL %s: got error %0d allowed +/-%0d", nm, diff, bound);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic int clamp8(int v, inout logic s);
    if (v > 127) begin s = 1'b1; return 127; end
    if (v < -128) begin s = 1'b1; return -128; end
    return v;
  endfunction

  // x = X + Y, y = conj(w)(X - Y) scaled by 2^-7 with floor, each clipped to 8 bits.
  function automatic logic [W-1:0] model(int xr, int xi, int yr, int yi, int wr, int wi);
    logic s;
    int dr, di, a, b, c, d;
    s  = 1'b0;
    dr = xr - yr;
    di = xi - yi;
    a  = clamp8(xr + yr, s);
    b  = clamp8(xi + yi, s);
    c  = clamp8((dr * wr + di * wi) >>> 7, s);
    d  = clamp8((di * wr - dr * wi) >>> 7, s);
    return {8'(a), 8'(b), 8'(c), 8'(d), s};
  endfunction

  // ---------------- compare process ----------------
  logic [CW-1:0] prev_out   = '0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  cur_word, e_word, r_word;

  always @(negedge clk) begin
    cur_word = {o_x_real, o_x_imag, o_y_real, o_y_imag, o_sat};
    if (i_reset) begin
      exp_q.delete();
      rt_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check_w("stall_hold", {6'd0, o_valid, cur_word}, prev_out);
      if (i_valid && o_ready) begin
        n_in++;
        exp_q.push_back(model(i_x_real, i_x_imag, i_y_real, i_y_imag,
                              i_twiddle_real, i_twiddle_imag));
        rt_q.push_back(drv_orig);
      end
      if (o_valid && i_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL out_unexpected: got word %h expected none", cur_word);
        end else begin
          e_word = exp_q.pop_front();
          r_word = rt_q.pop_front();
          check_w("out_word", {7'd0, cur_word}, {7'd0, e_word});
          if (r_word[32] && !o_sat) begin
            check_tol("rt_x_real", int'(o_x_real) - int'($signed(r_word[31:24])), 1);
            check_tol("rt_x_imag", int'(o_x_imag) - int'($signed(r_word[23:16])), 1);
            check_tol("rt_y_real", int'(o_y_real) - int'($signed(r_word[15:8])), 2);
            check_tol("rt_y_imag", int'(o_y_imag) - int'($signed(r_word[7:0])), 2);
          end
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_out   = {6'd0, o_valid, cur_word};
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_word(input int xr, xi, yr, yi, wr, wi, input logic [W-1:0] orig);
    logic acc;
    acc            = 1'b0;
    drv_orig       = orig;
    i_valid        = 1'b1;
    i_x_real       = 8'(xr);
    i_x_imag       = 8'(xi);
    i_y_real       = 8'(yr);
    i_y_imag       = 8'(yi);
    i_twiddle_real = 8'(wr);
    i_twiddle_imag = 8'(wi);
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", int'(acc), 1);
  endtask

  task automatic direct_vec(input int xr, xi, yr, yi, wr, wi,
                            input int exr, exi, eyr, eyi, es);
    check_w("model_pin", {7'd0, model(xr, xi, yr, yi, wr, wi)},
            {7'd0, 8'(exr), 8'(exi), 8'(eyr), 8'(eyi), 1'(es)});
    send_word(xr, xi, yr, yi, wr, wi, '0);
    i_valid = 1'b0;
    @(negedge clk);
    check("lat_after_1", int'(o_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_after_2", int'(o_valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_after_3", int'(o_valid), 1);
    check("lit_x_real", int'(o_x_real), exr);
    check("lit_x_imag", int'(o_x_imag), exi);
    check("lit_y_real", int'(o_y_real), eyr);
    check("lit_y_imag", int'(o_y_imag), eyi);
    check("lit_sat", int'(o_sat), es);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_o_valid"}, int'(o_valid), 0);
    check({tag, "_o_ready"}, int'(o_ready), 1);
    check({tag, "_o_x_real"}, int'(o_x_real), 0);
    check({tag, "_o_x_imag"}, int'(o_x_imag), 0);
    check({tag, "_o_y_real"}, int'(o_y_real), 0);
    check({tag, "_o_y_imag"}, int'(o_y_imag), 0);
    check({tag, "_o_sat"}, int'(o_sat), 0);
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int  base_in, base_out;
  bit  rnd_done;
  int  oxr, oxi, oyr, oyi, wr, wi, pr, pi, sel;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;

    // directed vectors with hand-computed results
    direct_vec(10, 0, 4, 0, 127, 0, 14, 0, 5, 0, 0);
    direct_vec(10, 0, 4, 0, 0, 127, 14, 0, 0, -6, 0);
    direct_vec(100, 0, 100, 0, 127, 0, 127, 0, 0, 0, 1);
    direct_vec(-100, 0, -100, 0, 127, 0, -128, 0, 0, 0, 1);
    direct_vec(-128, 0, 127, 0, -128, 0, -1, 0, 127, 0, 1);
    direct_vec(20, -10, -6, 8, 90, -90, 14, -2, 30, 5, 0);

    // backpressure: 6 words offered, consumer stalled for 5 cycles
    base_in = n_in;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send_word(10 * k - 20, k, 3 - k, -2 * k, 90, -90, '0);
        i_valid = 1'b0;
      end
      begin
        i_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        check("bp_accepted", n_in - base_in, 3);
        check("bp_o_ready_full", int'(o_ready), 0);
        check("bp_o_valid_full", int'(o_valid), 1);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_on_release", int'(o_ready), 1);
      end
    join
    wait_drain("bp");
    check("bp_all_out", n_in - base_in, 6);

    // reset with two words in flight
    @(posedge clk);
    #1;
    send_word(5, 5, 1, 1, 127, 0, '0);
    send_word(7, -3, 2, 2, 0, 127, '0);
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset  = 1'b0;
    base_out = n_out;
    @(negedge clk);
    check_idle("midreset");
    repeat (8) @(posedge clk);
    #1;
    check("flush_no_output", n_out - base_out, 0);

    // round trip: forward butterfly in the bench, then the DUT
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          oxr = int'($urandom_range(0, 80)) - 40;
          oxi = int'($urandom_range(0, 80)) - 40;
          oyr = int'($urandom_range(0, 40)) - 20;
          oyi = int'($urandom_range(0, 40)) - 20;
          sel = int'($urandom_range(0, 3));
          wr  = (sel == 0) ? 127 : (sel == 2) ? -127 : 0;
          wi  = (sel == 1) ? 127 : (sel == 3) ? -127 : 0;
          pr  = (wr * oyr - wi * oyi) >>> 7;
          pi  = (wr * oyi + wi * oyr) >>> 7;
          if ($urandom_range(0, 3) == 0) begin
            i_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send_word((oxr + pr) >>> 1, (oxi + pi) >>> 1, (oxr - pr) >>> 1, (oxi - pi) >>> 1,
                    wr, wi, {1'b1, 8'(oxr), 8'(oxi), 8'(oyr), 8'(oyi)});
        end
        i_valid  = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    wait_drain("rand");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
